// File: rtl/blink_pattern_if.sv
// Handshake and pattern bus between the blink sequencer and its controller.
// The controller drives the step strobe and sequence requests; the sequencer reports LED and status.
interface blink_pattern_if #(
  parameter int PBITS = 8,
  parameter int RBITS = 4
) ();
  localparam int SW = (PBITS > 1) ? $clog2(PBITS) : 1;

  logic             tick;
  logic             start;
  logic             abort;
  logic [PBITS-1:0] pattern;
  logic [RBITS-1:0] reps;
  logic             led;
  logic             busy;
  logic             done;
  logic [SW-1:0]    step;

  modport master (
    output tick, start, abort, pattern, reps,
    input  led, busy, done, step
  );

  modport slave (
    input  tick, start, abort, pattern, reps,
    output led, busy, done, step
  );
endinterface

// File: rtl/blink_pattern.sv
// Plays a captured bit pattern on an LED one bit per tick, repeated reps times
// with GAP_TICKS dark ticks between repetitions; all outputs are registered.
module blink_pattern #(
  parameter int PBITS     = 8,
  parameter int RBITS     = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic           clk,
  input  logic           rst,
  blink_pattern_if.slave bus
);
  localparam int SW = (PBITS > 1) ? $clog2(PBITS) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(PBITS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PBITS-1:0]   shadow_q, shadow_d;
  logic [RBITS-1:0]   rep_q, rep_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [SW-1:0]      step_q, step_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      step_q   <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      step_q   <= step_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.abort)       state_d = ST_IDLE;
        else if (rep_q == '0) state_d = ST_DONE;
        else                 state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort) state_d = ST_IDLE;
        else if (bus.tick && step_q == STEP_LAST) begin
          if (rep_q <= RBITS'(1))  state_d = ST_DONE;
          else if (GAP_TICKS > 0) state_d = ST_GAP;
          else                    state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        if (bus.abort) state_d = ST_IDLE;
        else if (bus.tick && gap_q == GAP_LAST) state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    step_d   = step_q;
    led_d    = led_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shadow_d = bus.pattern;
          rep_d    = bus.reps;
        end
      end
      ST_RUN: begin
        if (!bus.abort && bus.tick) begin
          led_d = shadow_q[step_q];
          if (step_q == STEP_LAST) begin
            step_d = '0;
            rep_d  = (rep_q != '0) ? rep_q - RBITS'(1) : '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      ST_GAP: begin
        if (!bus.abort && bus.tick) begin
          led_d = 1'b0;
          gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + GW'(1);
        end
      end
      default: ;
    endcase

    // Anything headed for IDLE (DONE exit or abort) goes dark with the step index cleared.
    if (state_d == ST_IDLE) begin
      led_d  = 1'b0;
      step_d = '0;
      gap_d  = '0;
    end
  end

  always_comb begin
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.step = step_q;
endmodule

// File: tb/tb_blink_pattern.sv
// Directed self-checking bench for blink_pattern: basic run, gap repeat, zero reps,
// abort, asynchronous reset and ignored inputs, with hand-computed LED sequences.
module tb_blink_pattern;
  localparam int PBITS = 8;
  localparam int RBITS = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   d0;
  logic [7:0] exp_a;

  blink_pattern_if #(.PBITS(PBITS), .RBITS(RBITS)) bus ();

  blink_pattern #(.PBITS(PBITS), .RBITS(RBITS), .GAP_TICKS(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  task automatic start_seq(input logic [7:0] pat, input logic [3:0] r);
    bus.pattern = pat;
    bus.reps    = r;
    bus.start   = 1'b1;
    cyc(1);
    bus.start   = 1'b0;
  endtask

  // One full repetition with reps=1: eight ticks one cycle apart, then DONE.
  task automatic run_single(input string tag, input logic [7:0] pat);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      pulse_tick();
      check({tag, "_led"}, 32'(bus.led), 32'(pat[i]));
      check({tag, "_step"}, 32'(bus.step), 32'((i + 1) % 8));
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    cyc(1);
  endtask

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern = '0; bus.reps = '0;
    #2;
    check("rst_led",  32'(bus.led),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_step", 32'(bus.step), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Basic run, with a coincident tick on start and start/pattern/reps changes mid-run.
    d0 = done_cnt;
    exp_a = 8'b1010_0011;
    bus.pattern = exp_a; bus.reps = 4'd1; bus.start = 1'b1; bus.tick = 1'b1;
    cyc(1);
    bus.start = 1'b0; bus.tick = 1'b0;
    check("b_load_busy", 32'(bus.busy), 32'd1);
    check("b_load_led",  32'(bus.led),  32'd0);
    cyc(1);
    check("b_run_step",  32'(bus.step), 32'd0);
    check("b_run_led",   32'(bus.led),  32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.start = 1'b1; bus.pattern = 8'h00; bus.reps = 4'hF;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
      end else begin
        cyc(3);
      end
      pulse_tick();
      check("b_led",  32'(bus.led),  32'(exp_a[i]));
      check("b_step", 32'(bus.step), 32'((i + 1) % 8));
      check("b_busy", 32'(bus.busy), (i < 7) ? 32'd1 : 32'd0);
      check("b_done", 32'(bus.done), (i < 7) ? 32'd0 : 32'd1);
    end
    cyc(1);
    check("b_idle_led",  32'(bus.led),  32'd0);
    check("b_idle_done", 32'(bus.done), 32'd0);
    pulse_tick();
    cyc(1);
    pulse_tick();
    check("b_idle_tick_led",  32'(bus.led),  32'd0);
    check("b_idle_tick_step", 32'(bus.step), 32'd0);
    check("b_idle_tick_busy", 32'(bus.busy), 32'd0);
    check("b_done_count", 32'(done_cnt - d0), 32'd1);

    // Zero repetitions: IDLE, LOAD, DONE.
    start_seq(8'hFF, 4'd0);
    check("z_load_busy", 32'(bus.busy), 32'd1);
    check("z_load_done", 32'(bus.done), 32'd0);
    cyc(1);
    check("z_done",      32'(bus.done), 32'd1);
    check("z_done_busy", 32'(bus.busy), 32'd0);
    check("z_done_led",  32'(bus.led),  32'd0);
    cyc(1);
    check("z_idle_done", 32'(bus.done), 32'd0);
    check("z_idle_led",  32'(bus.led),  32'd0);

    // Two repetitions of all-ones with a two-tick gap.
    d0 = done_cnt;
    start_seq(8'hFF, 4'd2);
    cyc(1);
    for (int k = 0; k < 18; k++) begin
      cyc(1);
      pulse_tick();
      check("g_led", 32'(bus.led), (k == 8 || k == 9) ? 32'd0 : 32'd1);
      check("g_step", 32'(bus.step),
            (k < 8) ? 32'((k + 1) % 8) : (k < 10) ? 32'd0 : 32'((k - 9) % 8));
      check("g_busy", 32'(bus.busy), (k < 17) ? 32'd1 : 32'd0);
    end
    check("g_done", 32'(bus.done), 32'd1);
    cyc(2);
    check("g_done_count", 32'(done_cnt - d0), 32'd1);

    // Abort together with the fourth tick of a three-repetition run.
    d0 = done_cnt;
    start_seq(8'hFF, 4'd3);
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      pulse_tick();
      check("a_led", 32'(bus.led), 32'd1);
    end
    cyc(1);
    bus.abort = 1'b1; bus.tick = 1'b1;
    cyc(1);
    bus.abort = 1'b0; bus.tick = 1'b0;
    check("a_led_off", 32'(bus.led),  32'd0);
    check("a_step",    32'(bus.step), 32'd0);
    check("a_busy",    32'(bus.busy), 32'd0);
    check("a_done",    32'(bus.done), 32'd0);
    cyc(3);
    check("a_no_done", 32'(done_cnt - d0), 32'd0);
    start_seq(8'h36, 4'd1);
    cyc(1);
    run_single("a_rerun", 8'h36);

    // Asynchronous reset between edges while in GAP.
    start_seq(8'hFF, 4'd2);
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      pulse_tick();
    end
    check("r_gap_led",  32'(bus.led),  32'd1);
    check("r_gap_busy", 32'(bus.busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("r_led",  32'(bus.led),  32'd0);
    check("r_busy", 32'(bus.busy), 32'd0);
    check("r_step", 32'(bus.step), 32'd0);
    check("r_done", 32'(bus.done), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pulse_tick();
    check("r_wait_busy", 32'(bus.busy), 32'd0);
    check("r_wait_led",  32'(bus.led),  32'd0);
    start_seq(8'h01, 4'd1);
    cyc(1);
    run_single("r_fresh", 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
